usb_link_ctrl: RTL

- Half-duplex line controller for the USB full-speed PHY.
- Arbitrates the shared D+/D- pair between the receive path and transmit requests from the SIE.
- Drives the receiver enable, enforces bus turnaround, and grants transmit.
- Monitors LineState for bus reset (SE0 ≥ 2.5 µs) and suspend (idle J ≥ 3 ms). All timing is in full-speed bit times, counted on fs_ce.

---
 rtl/usb_link_pkg.sv | 25 ++
 rtl/usb_link_ctrl_if.sv | 26 ++
 rtl/usb_link_ctrl_line_timer.sv | 43 ++++
 rtl/usb_link_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/usb_link_pkg.sv
// Shared definitions for the USB full-speed link controller: state encoding,
// LineState codes and default timing constants (all in full-speed bit times).
package usb_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RX   = 3'd1,
        ST_TA   = 3'd2,
        ST_GNT  = 3'd3,
        ST_TX   = 3'd4
    } link_state_e;

    // LineState is {D-,D+}
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam int TA_BITS_DEF     = 2;
    localparam int GNT_TO_BITS_DEF = 4;
    localparam int RST_BITS_DEF    = 30;
    localparam int SUSP_BITS_DEF   = 36000;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/usb_link_ctrl_if.sv
// Signal bundle between the PHY/SIE side (master) and the link controller (slave).
interface usb_link_ctrl_if;

    logic       fs_ce;
    logic [1:0] LineState;
    logic       RxActive;
    logic       TxReq;
    logic       TxActive;
    logic       RxEn;
    logic       TxGrant;
    logic       tx_abort;
    logic       usb_rst;
    logic       suspend;
    logic [2:0] link_state;

    modport master (
        output fs_ce, LineState, RxActive, TxReq, TxActive,
        input  RxEn, TxGrant, tx_abort, usb_rst, suspend, link_state
    );

    modport slave (
        input  fs_ce, LineState, RxActive, TxReq, TxActive,
        output RxEn, TxGrant, tx_abort, usb_rst, suspend, link_state
    );

endinterface

// File: rtl/usb_link_ctrl_line_timer.sv
// Saturating run-length counter of bit times: counts matching fs_ce samples,
// restarts on any non-matching sample or on clr, flags hit once LIMIT is reached.
module usb_line_timer #(
    parameter int W     = 16,
    parameter int LIMIT = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic fs_ce_i,
    input  logic match_i,
    input  logic clr_i,
    output logic hit_o
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (fs_ce_i) begin
            if (!match_i) begin
                cnt_d = '0;
            end else if (cnt_q != LIM) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == LIM);

endmodule

// File: rtl/usb_link_ctrl.sv
// Half-duplex full-speed line controller: arbitrates the D+/D- pair between
// receive and SIE transmit, enforces turnaround, detects bus reset and suspend.
module usb_link_ctrl
    import usb_link_pkg::*;
#(
    parameter int TA_BITS     = TA_BITS_DEF,
    parameter int GNT_TO_BITS = GNT_TO_BITS_DEF,
    parameter int RST_BITS    = RST_BITS_DEF,
    parameter int SUSP_BITS   = SUSP_BITS_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    usb_link_ctrl_if.slave  link
);

    localparam logic [CNT_W-1:0] TA_LIM = CNT_W'(TA_BITS);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(GNT_TO_BITS);

    link_state_e      state_q;
    logic [CNT_W-1:0] ta_cnt_q;
    logic [CNT_W-1:0] to_cnt_q;
    logic             rx_en_q;
    logic             tx_grant_q;
    logic             tx_abort_q;

    logic se0_hit;
    logic j_hit;
    logic line_j;
    logic j_window;

    assign line_j   = (link.LineState == LS_J);
    assign j_window = (state_q == ST_IDLE) || (state_q == ST_TA);

    usb_line_timer #(
        .W     (CNT_W),
        .LIMIT (RST_BITS)
    ) u_se0_timer (
        .clk     (clk),
        .rst     (rst),
        .fs_ce_i (link.fs_ce),
        .match_i (link.LineState == LS_SE0),
        .clr_i   (1'b0),
        .hit_o   (se0_hit)
    );

    // Bus activity of any kind (receive or a pending transmit) restarts the idle-J run.
    usb_line_timer #(
        .W     (CNT_W),
        .LIMIT (SUSP_BITS)
    ) u_j_timer (
        .clk     (clk),
        .rst     (rst),
        .fs_ce_i (link.fs_ce),
        .match_i (line_j && j_window),
        .clr_i   (link.RxActive || link.TxReq),
        .hit_o   (j_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ta_cnt_q   <= '0;
            to_cnt_q   <= '0;
            rx_en_q    <= 1'b1;
            tx_grant_q <= 1'b0;
            tx_abort_q <= 1'b0;
        end else begin
            tx_abort_q <= 1'b0;
            // A detected bus reset pins the link in IDLE until the SE0 ends.
            if (se0_hit) begin
                state_q    <= ST_IDLE;
                ta_cnt_q   <= '0;
                to_cnt_q   <= '0;
                rx_en_q    <= 1'b1;
                tx_grant_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        rx_en_q    <= 1'b1;
                        tx_grant_q <= 1'b0;
                        if (link.RxActive) begin
                            state_q <= ST_RX;
                        end else if (link.TxReq) begin
                            state_q  <= ST_TA;
                            ta_cnt_q <= '0;
                        end
                    end
                    ST_RX: begin
                        if (!link.RxActive) begin
                            state_q  <= ST_TA;
                            ta_cnt_q <= '0;
                        end
                    end
                    ST_TA: begin
                        if (link.RxActive) begin
                            state_q  <= ST_RX;
                            ta_cnt_q <= '0;
                        end else if (ta_cnt_q == TA_LIM) begin
                            ta_cnt_q <= '0;
                            if (link.TxReq) begin
                                state_q    <= ST_GNT;
                                to_cnt_q   <= '0;
                                tx_grant_q <= 1'b1;
                                rx_en_q    <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else if (link.fs_ce) begin
                            ta_cnt_q <= line_j ? ta_cnt_q + 1'b1 : '0;
                        end
                    end
                    ST_GNT: begin
                        if (link.TxActive) begin
                            state_q <= ST_TX;
                        end else if (to_cnt_q == TO_LIM) begin
                            state_q    <= ST_IDLE;
                            to_cnt_q   <= '0;
                            tx_grant_q <= 1'b0;
                            rx_en_q    <= 1'b1;
                            tx_abort_q <= 1'b1;
                        end else if (link.fs_ce) begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    ST_TX: begin
                        // End of EOP goes through TA so the bus gets its turnaround gap.
                        if (!link.TxActive) begin
                            state_q    <= ST_TA;
                            ta_cnt_q   <= '0;
                            tx_grant_q <= 1'b0;
                            rx_en_q    <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        ta_cnt_q   <= '0;
                        to_cnt_q   <= '0;
                        rx_en_q    <= 1'b1;
                        tx_grant_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign link.RxEn       = rx_en_q;
    assign link.TxGrant    = tx_grant_q;
    assign link.tx_abort   = tx_abort_q;
    assign link.usb_rst    = se0_hit;
    assign link.suspend    = j_hit;
    assign link.link_state = state_q;

endmodule
